// File: rtl/approx_adder_pkg.sv
// rtl/approx_adder_pkg.sv - shared defaults, stage count helper and stage control record
package approx_adder_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_SEG_W       = 4;
  localparam int DEF_APPROX_BITS = 4;

  function automatic int calc_nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Control half of a pipeline stage record; the top wraps it with width-dependent fields.
  typedef struct packed {
    logic valid;
    logic approx;
    logic carry;
  } stage_ctrl_t;

endpackage

// File: rtl/rca_segment.sv
// rtl/rca_segment.sv - combinational ripple segment; bits set in or_mask use a|b instead of a full add
module rca_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic [SEG_W-1:0] or_mask,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout
);

  // An OR bit forwards a&b as its carry, which yields the LOA carry into the first exact bit.
  always_comb begin
    logic c;
    c   = cin;
    sum = '0;
    for (int j = 0; j < SEG_W; j++) begin
      if (or_mask[j]) begin
        sum[j] = a[j] | b[j];
        c      = a[j] & b[j];
      end else begin
        sum[j] = a[j] ^ b[j] ^ c;
        c      = (a[j] & b[j]) | (c & (a[j] ^ b[j]));
      end
    end
    cout = c;
  end

endmodule

// File: rtl/pipelined_approx_adder.sv
// rtl/pipelined_approx_adder.sv - segment-pipelined adder with runtime lower-part-OR mode
// Optional ERROR_MON_EN adds an exact shadow path and an approximation error monitor.
module pipelined_approx_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SEG_W       = DEF_SEG_W,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             out_approx
`ifdef ERROR_MON_EN
  ,
  input  logic             err_clr,
  output logic [31:0]      err_count,
  output logic [WIDTH:0]   err_max
`endif
);

  localparam int NSEG = calc_nseg(WIDTH, SEG_W);
  localparam logic [WIDTH-1:0] LOA_MASK = ~({WIDTH{1'b1}} << APPROX_BITS);

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_t;

  stage_t           st_q [NSEG];
  stage_t           src  [NSEG];
  stage_t           st_d [NSEG];
  logic [SEG_W-1:0] seg_s  [NSEG];
  logic             seg_co [NSEG];
  logic             advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 0 starts from carry 0: the OR bits themselves generate the LOA carry.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    if (gi == 0) begin : g_first
      assign src[gi] = {in_valid, approx_en, 1'b0, {WIDTH{1'b0}}, a, b};
    end else begin : g_rest
      assign src[gi] = st_q[gi-1];
    end

    rca_segment #(.SEG_W(SEG_W)) u_seg (
      .a       (src[gi].a[gi*SEG_W +: SEG_W]),
      .b       (src[gi].b[gi*SEG_W +: SEG_W]),
      .or_mask (src[gi].ctrl.approx ? LOA_MASK[gi*SEG_W +: SEG_W] : {SEG_W{1'b0}}),
      .cin     (src[gi].ctrl.carry),
      .sum     (seg_s[gi]),
      .cout    (seg_co[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < NSEG; i++) begin
      st_d[i]                          = src[i];
      st_d[i].psum[i*SEG_W +: SEG_W]   = seg_s[i];
      st_d[i].ctrl.carry               = seg_co[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) st_q[i] <= '0;
    end else if (advance) begin
      for (int i = 0; i < NSEG; i++) st_q[i] <= st_d[i];
    end
  end

  assign out_valid  = st_q[NSEG-1].ctrl.valid;
  assign out_approx = st_q[NSEG-1].ctrl.approx;
  assign sum        = {st_q[NSEG-1].ctrl.carry, st_q[NSEG-1].psum};

`ifdef ERROR_MON_EN
  logic [WIDTH:0] ex_q [NSEG];
  logic [WIDTH:0] err_diff;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NSEG; i++) ex_q[i] <= '0;
    end else if (advance) begin
      ex_q[0] <= {1'b0, a} + {1'b0, b};
      for (int i = 1; i < NSEG; i++) ex_q[i] <= ex_q[i-1];
    end
  end

  always_comb begin
    err_diff = (sum >= ex_q[NSEG-1]) ? (sum - ex_q[NSEG-1]) : (ex_q[NSEG-1] - sum);
  end

  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_count <= '0;
      err_max   <= '0;
    end else if (out_valid && out_ready && out_approx && (err_diff != '0)) begin
      if (err_count != 32'hFFFF_FFFF) err_count <= err_count + 32'd1;
      if (err_diff > err_max) err_max <= err_diff;
    end
  end
`endif

endmodule
